// File: rtl/pp_mult_scheduler.sv
// Two-requester round-robin front end for one row-serial shift-and-add multiplier.
// Each job produces one partial-product row per cycle and holds the product until the consumer takes it.
module pp_mult_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_x,
  input  logic [WIDTH-1:0]   req0_y,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_x,
  input  logic [WIDTH-1:0]   req1_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_id,
  output logic               busy
);

  localparam int KW = $clog2(WIDTH + 1);
  localparam logic [KW-1:0] KLAST = KW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic               last_grant;
  logic               grant;
  logic               accept;
  logic               id_r;
  logic [2*WIDTH-1:0] x_sh;
  logic [WIDTH-1:0]   y_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] row;
  logic [KW-1:0]      k;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant goes to the lone valid requester, or to the one that did not win last time.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
        accept     = (req0_valid & ~grant) | (req1_valid & grant);
        if (accept) state_next = RUN;
      end
      RUN: begin
        if (k == KLAST) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // x is pre-shifted and y consumed LSB first, so row k is simply x_sh gated by y_sh[0].
  assign row = x_sh & {(2*WIDTH){y_sh[0]}};

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      id_r       <= 1'b0;
      x_sh       <= '0;
      y_sh       <= '0;
      acc        <= '0;
      k          <= '0;
      out_p      <= '0;
      out_valid  <= 1'b0;
      out_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_sh       <= {{WIDTH{1'b0}}, (grant ? req1_x : req0_x)};
            y_sh       <= grant ? req1_y : req0_y;
            id_r       <= grant;
            last_grant <= grant;
            acc        <= '0;
            k          <= '0;
          end
        end
        RUN: begin
          if (k != KLAST) begin
            acc  <= acc + row;
            x_sh <= x_sh << 1;
            y_sh <= y_sh >> 1;
            k    <= k + KW'(1);
          end else begin
            out_p     <= acc;
            out_valid <= 1'b1;
            out_id    <= id_r;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pp_mult_scheduler.sv
// Randomized self-checking bench for pp_mult_scheduler against a plain x*y and round-robin model.
module tb_pp_mult_scheduler;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;
  logic             out_valid;
  logic             out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic             out_id;
  logic             busy;

  int errors = 0;
  int checks = 0;
  logic model_last;

  pp_mult_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_id(out_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  // One job from issue to handshake; entered and left just after a rising edge with the DUT idle.
  task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                               input logic v1, input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1,
                               input int stall);
    logic g;
    logic [2*WIDTH-1:0] exp_p;
    logic [2*WIDTH-1:0] held_p;
    int edges;
    req0_valid = v0; req0_x = x0; req0_y = y0;
    req1_valid = v1; req1_x = x1; req1_y = y1;
    out_ready  = 1'b0;
    g = (v0 && v1) ? !model_last : v1;
    exp_p = g ? (2*WIDTH)'(int'(x1) * int'(y1)) : (2*WIDTH)'(int'(x0) * int'(y0));
    #1;
    checkOutput("req0_ready_idle", 32'(req0_ready), 32'(v0 && !g));
    checkOutput("req1_ready_idle", 32'(req1_ready), 32'(v1 && g));
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_last = g;
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("latency", 32'(edges), 32'(WIDTH + 1));
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("out_p", 32'(out_p), 32'(exp_p));
    checkOutput("out_id", 32'(out_id), 32'(g));
    checkOutput("busy_done", 32'(busy), 32'd1);
    held_p = out_p;
    for (int s = 0; s < stall; s++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checkOutput("ready_done", 32'({req0_ready, req1_ready}), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_p", 32'(out_p), 32'(held_p));
      checkOutput("hold_id", 32'(out_id), 32'(g));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("valid_after_hs", 32'(out_valid), 32'd0);
    checkOutput("busy_after_hs", 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    doReset();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_p", 32'(out_p), 32'd0);
    checkOutput("rst_out_id", 32'(out_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_readys", 32'({req0_ready, req1_ready}), 32'd0);

    applyStimulus(1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 0);
    checkOutput("ff_model", 32'(int'(4'hF) * int'(4'hF)), 32'h00E1);

    doReset();
    applyStimulus(1'b1, 4'h3, 4'h5, 1'b1, 4'h7, 4'h2, 0);
    applyStimulus(1'b1, 4'h3, 4'h5, 1'b1, 4'h7, 4'h2, 0);
    applyStimulus(1'b1, 4'h3, 4'h5, 1'b1, 4'h7, 4'h2, 0);

    applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'h9, 4'h0, 0);
    applyStimulus(1'b1, 4'h0, 4'hA, 1'b0, 4'h0, 4'h0, 0);
    applyStimulus(1'b1, 4'h6, 4'h7, 1'b0, 4'h0, 4'h0, 10);

    // Reset lands during the second RUN cycle; the job must vanish.
    req0_valid = 1'b1; req0_x = 4'hF; req0_y = 4'hF;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_last = 1'b1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_p", 32'(out_p), 32'd0);
    checkOutput("midrst_id", 32'(out_id), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("midrst_no_valid", 32'(seen), 32'd0);
    applyStimulus(1'b1, 4'h2, 4'h3, 1'b0, 4'h0, 4'h0, 0);

    // Every operand pair, routed to whichever requester the round-robin rule will grant.
    for (int i = 0; i < 256; i++) begin
      logic want, both, g;
      logic [WIDTH-1:0] px, py, rx, ry;
      px = WIDTH'(i >> 4);
      py = WIDTH'(i);
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      want = i[0];
      both = 1'($urandom_range(0, 1));
      g = both ? !model_last : want;
      if (g)
        applyStimulus(both, rx, ry, 1'b1, px, py, $urandom_range(0, 2));
      else
        applyStimulus(1'b1, px, py, both, rx, ry, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
